// File: rtl/two24_pkg.sv
// Shared types and constants for blocks that time-share a dual-24-bit SIMD DSP adder.
package two24_pkg;

  localparam int unsigned TWO24_DSP_W  = 48;
  localparam int unsigned TWO24_LANE_W = 24;

  // Owner index field is sized for the largest supported requester count (16).
  localparam int unsigned TAG_IDX_W = 4;

  // Lane carry order on CARRY buses: {hi, lo}.
  localparam int unsigned CARRY_LO_BIT = 0;
  localparam int unsigned CARRY_HI_BIT = 1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant to the first request at or after the
// pointer (with wrap), pointer moves just past the winner when advance_i is high.
module rr_arbiter #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic             advance_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int unsigned      cand;

  // Search upward from the pointer, wrapping, and grant the first requester found.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!found && en_i && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

  // Pointer moves to (winner + 1) mod NREQ on an accepted grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (grant_idx_o == IDX_W'(NREQ - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/two24_dsp_sched.sv
// Round-robin scheduler sharing one two24_dsp adder slice among NREQ requesters.
// Owner tags ride a shift register alongside the DSP pipeline so each result
// returns to its requester, strictly in grant order.
module two24_dsp_sched
  import two24_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DSP_LAT = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [NREQ*TWO24_DSP_W-1:0] req_ab_i,
  input  logic [NREQ*TWO24_DSP_W-1:0] req_c_i,
  output logic [TWO24_DSP_W-1:0]      dsp_ab_o,
  output logic [TWO24_DSP_W-1:0]      dsp_c_o,
  output logic                        dsp_ce_o,
  input  logic [TWO24_DSP_W-1:0]      dsp_p_i,
  input  logic [1:0]                  dsp_carry_i,
  output logic [NREQ-1:0]             res_valid_o,
  output logic [TWO24_DSP_W-1:0]      res_p_o,
  output logic [1:0]                  res_carry_o,
  output logic                        busy_o
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(DSP_LAT + 3);

  logic [NREQ-1:0]        grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   hs;
  logic [TWO24_DSP_W-1:0] ab_sel, c_sel;

  logic [TWO24_DSP_W-1:0] ab_q, c_q;
  logic                   ce_q;
  tag_t                   issue_tag_q;
  tag_t [DSP_LAT:0]       tag_q;
  tag_t                   fin_tag;

  logic [NREQ-1:0]        strobe_d, res_valid_q;
  logic [TWO24_DSP_W-1:0] res_p_q;
  logic [1:0]             res_carry_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (enable_i),
    .req_i      (req_valid_i),
    .advance_i  (hs),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // Grant already implies valid, so any grant bit is a handshake.
  assign hs          = |grant;
  assign req_ready_o = grant;
  assign fin_tag     = tag_q[DSP_LAT];

  // One-hot operand select for the granted requester.
  always_comb begin
    ab_sel = '0;
    c_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        ab_sel = ab_sel | req_ab_i[i*TWO24_DSP_W +: TWO24_DSP_W];
        c_sel  = c_sel  | req_c_i[i*TWO24_DSP_W +: TWO24_DSP_W];
      end
    end
  end

  // Decode the retiring tag into the owner strobe.
  always_comb begin
    strobe_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      strobe_d[i] = fin_tag.valid && (fin_tag.idx == TAG_IDX_W'(i));
    end
  end

  // In-flight count: +1 per handshake, -1 per retiring tag.
  always_comb begin
    cnt_d = cnt_q;
    if (hs && !fin_tag.valid) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!hs && fin_tag.valid) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Issue registers, tag pipeline, result capture and in-flight count.
  // CE is held high out of reset (a low CE would freeze the DSP's P register),
  // so the tags shift on every edge in lockstep with the slice.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ce_q        <= 1'b0;
      ab_q        <= '0;
      c_q         <= '0;
      issue_tag_q <= '0;
      tag_q       <= '0;
      res_valid_q <= '0;
      res_p_q     <= '0;
      res_carry_q <= '0;
      cnt_q       <= '0;
    end else begin
      ce_q              <= 1'b1;
      issue_tag_q.valid <= hs;
      issue_tag_q.idx   <= TAG_IDX_W'(grant_idx);
      if (hs) begin
        ab_q <= ab_sel;
        c_q  <= c_sel;
      end
      tag_q       <= {tag_q[DSP_LAT-1:0], issue_tag_q};
      res_valid_q <= strobe_d;
      if (fin_tag.valid) begin
        res_p_q     <= dsp_p_i;
        res_carry_q <= {dsp_carry_i[CARRY_HI_BIT], dsp_carry_i[CARRY_LO_BIT]};
      end
      cnt_q <= cnt_d;
    end
  end

  assign dsp_ab_o    = ab_q;
  assign dsp_c_o     = c_q;
  assign dsp_ce_o    = ce_q;
  assign res_valid_o = res_valid_q;
  assign res_p_o     = res_p_q;
  assign res_carry_o = res_carry_q;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: tb/tb_two24_dsp_sched.sv
// Bench for two24_dsp_sched: behavioural DSP slice, round-robin grant model and
// an in-order result scoreboard, plus directed vectors and corner sequences.
module tb_two24_dsp_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DSP_LAT = 2;
  localparam int unsigned W       = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   valid, ready, res_valid;
  logic [NREQ*W-1:0] req_ab, req_c;
  logic [W-1:0]      dsp_ab, dsp_c, dsp_p, res_p;
  logic              dsp_ce, busy;
  logic [1:0]        dsp_carry, res_carry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two24_dsp_sched #(
    .NREQ   (NREQ),
    .DSP_LAT(DSP_LAT)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .enable_i   (en),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_ab_i   (req_ab),
    .req_c_i    (req_c),
    .dsp_ab_o   (dsp_ab),
    .dsp_c_o    (dsp_c),
    .dsp_ce_o   (dsp_ce),
    .dsp_p_i    (dsp_p),
    .dsp_carry_i(dsp_carry),
    .res_valid_o(res_valid),
    .res_p_o    (res_p),
    .res_carry_o(res_carry),
    .busy_o     (busy)
  );

  // Reference dual-lane adder: returns {carry_hi, carry_lo, p}.
  function automatic logic [49:0] ref_add(input logic [47:0] ab, input logic [47:0] c);
    logic [24:0] lo, hi;
    lo = {1'b0, ab[23:0]} + {1'b0, c[23:0]};
    hi = {1'b0, ab[47:24]} + {1'b0, c[47:24]};
    return {hi[24], lo[24], hi[23:0], lo[23:0]};
  endfunction

  // DSP slice model: AB/C capture register, then DSP_LAT result stages.
  logic [47:0] m_ab, m_c;
  logic [49:0] m_pipe [DSP_LAT];
  always @(posedge clk) begin
    if (dsp_ce) begin
      m_ab      <= dsp_ab;
      m_c       <= dsp_c;
      m_pipe[0] <= ref_add(m_ab, m_c);
      for (int k = 1; k < DSP_LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end
  assign dsp_p     = m_pipe[DSP_LAT-1][47:0];
  assign dsp_carry = m_pipe[DSP_LAT-1][49:48];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          owner;
    logic [47:0] p;
    logic [1:0]  carry;
    int          cyc;
  } sb_t;

  sb_t  sb_q[$];
  int   gnt_log[$];
  int   mptr = 0;
  int   ncyc = 0;
  int   res_cnt [NREQ];
  int   last_owner, last_lat;
  logic [47:0] last_p;
  logic [1:0]  last_carry;

  // Monitor: checks strobes against the scoreboard, busy against the bench's
  // own in-flight count, and ready against a round-robin model.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      mptr = 0;
    end else begin
      logic [NREQ-1:0] exp_rdy;
      logic [49:0]     r;
      int              gi;
      ncyc++;
      if (res_valid != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 64'(res_valid), 64'd0);
        end else begin
          sb_t             e;
          logic [NREQ-1:0] ev;
          e = sb_q.pop_front();
          ev = '0;
          ev[e.owner] = 1'b1;
          chk("res_owner", 64'(res_valid), 64'(ev));
          chk("res_p", 64'(res_p), 64'(e.p));
          chk("res_carry", 64'(res_carry), 64'(e.carry));
          last_owner = e.owner;
          last_p     = res_p;
          last_carry = res_carry;
          last_lat   = ncyc - e.cyc - 1;
          chk("res_latency", 64'(last_lat), 64'(DSP_LAT + 2));
          res_cnt[e.owner]++;
        end
      end
      chk("busy", 64'(busy), 64'(sb_q.size() != 0));
      exp_rdy = '0;
      gi = -1;
      if (en) begin
        for (int k = 0; k < NREQ; k++) begin
          int cand;
          cand = (mptr + k) % NREQ;
          if (gi < 0 && valid[cand]) gi = cand;
        end
      end
      if (gi >= 0) exp_rdy[gi] = 1'b1;
      chk("ready", 64'(ready), 64'(exp_rdy));
      if (gi >= 0) begin
        sb_t e;
        r = ref_add(req_ab[gi*W +: W], req_c[gi*W +: W]);
        e.owner = gi;
        e.p     = r[47:0];
        e.carry = r[49:48];
        e.cyc   = ncyc;
        sb_q.push_back(e);
        gnt_log.push_back(gi);
        mptr = (gi + 1) % NREQ;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [47:0] ab, input logic [47:0] c);
    req_ab[r*W +: W] = ab;
    req_c[r*W +: W]  = c;
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  task automatic drain();
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) cyc();
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_p"}, 64'(res_p), 64'd0);
    chk({tag, "_res_carry"}, 64'(res_carry), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_dsp_ab"}, 64'(dsp_ab), 64'd0);
    chk({tag, "_dsp_c"}, 64'(dsp_c), 64'd0);
    chk({tag, "_dsp_ce"}, 64'(dsp_ce), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  typedef struct {
    int          req;
    logic [47:0] ab;
    logic [47:0] c;
    logic [47:0] exp_p;
    logic [1:0]  exp_carry;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{2, 48'h000001_000002, 48'h000003_000004, 48'h000004_000006, 2'b00};
    vecs[1] = '{0, 48'hFFFFFF_FFFFFF, 48'h000001_000001, 48'h000000_000000, 2'b11};
    vecs[2] = '{1, 48'h800000_000000, 48'h800000_000001, 48'h000000_000001, 2'b10};
    vecs[3] = '{3, 48'h000000_FFFFFF, 48'h123456_000002, 48'h123456_000001, 2'b01};
    vecs[4] = '{1, 48'h7FFFFF_ABCDEF, 48'h000001_111111, 48'h800000_BCDF00, 2'b00};

    rst_n  = 1'b0;
    en     = 1'b0;
    valid  = '0;
    req_ab = '0;
    req_c  = '0;
    for (int i = 0; i < NREQ; i++) res_cnt[i] = 0;
    repeat (2) cyc();
    check_idle("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    cyc();

    // Directed vectors, one isolated request each.
    foreach (vecs[v]) begin
      last_owner = -1;
      set_op(vecs[v].req, vecs[v].ab, vecs[v].c);
      valid = '0;
      valid[vecs[v].req] = 1'b1;
      cyc();
      valid = '0;
      chk("vec_dsp_ce", 64'(dsp_ce), 64'd1);
      chk("vec_dsp_ab", 64'(dsp_ab), 64'(vecs[v].ab));
      drain();
      chk("vec_owner", 64'(last_owner), 64'(vecs[v].req));
      chk("vec_p", 64'(last_p), 64'(vecs[v].exp_p));
      chk("vec_carry", 64'(last_carry), 64'(vecs[v].exp_carry));
      chk("vec_latency", 64'(last_lat), 64'd4);
    end

    // Round-robin fairness: all requesters valid for 12 cycles from pointer 0.
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) res_cnt[i] = 0;
    valid = '1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, rnd48(), rnd48());
      cyc();
    end
    valid = '0;
    drain();
    chk("rr_grant_count", 64'(gnt_log.size()), 64'd12);
    for (int t = 0; t < 12 && t < gnt_log.size(); t++) begin
      chk("rr_order", 64'(gnt_log[t]), 64'(t % 4));
    end
    for (int i = 0; i < NREQ; i++) chk("rr_results", 64'(res_cnt[i]), 64'd3);

    // Enable deassert with three operations in flight.
    for (int i = 0; i < NREQ; i++) res_cnt[i] = 0;
    valid = 4'b0111;
    repeat (3) cyc();
    en = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("en_low_ready", 64'(ready), 64'd0);
      cyc();
    end
    drain();
    chk("en_low_results", 64'(res_cnt[0] + res_cnt[1] + res_cnt[2]), 64'd3);
    chk("en_low_busy", 64'(busy), 64'd0);
    chk("en_low_strobe_done", 64'(res_valid), 64'd0);
    valid = '0;
    en    = 1'b1;
    cyc();

    // Reset one cycle after two handshakes: in-flight work is discarded.
    valid = 4'b1010;
    repeat (2) cyc();
    valid = '0;
    cyc();
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("midrst_busy", 64'(busy), 64'd0);
    valid = '1;
    #1;
    chk("midrst_next_grant", 64'(ready), 64'd1);
    cyc();
    valid = '0;
    drain();

    // Sparse random traffic against the scoreboard.
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        valid[i] = ($urandom_range(99) < 30);
        set_op(i, rnd48(), rnd48());
      end
      cyc();
    end
    valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
